// File: rtl/alu16_op_issuer_if.sv
// Host/ALU bundle for the ALU16 operation issuer.
// The issuer connects through the slave modport; the environment around it
// (processor sequencer on the request/response side, ALU16 on the other) uses master.
interface alu16_op_issuer_if #(
  parameter int W = 16
);
  // Request channel
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_x;
  logic [W-1:0] req_y;

  // ALU control unit / datapath handshake
  logic         alu_start;
  logic [3:0]   alu_s;
  logic [W-1:0] alu_inbus;
  logic         alu_finish;
  logic [W-1:0] alu_outbus;

  // Response channel
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_hi;
  logic [W-1:0] rsp_lo;
  logic         rsp_err;

  // Status
  logic         busy;

  modport master (
    output req_valid, req_op, req_x, req_y, alu_finish, alu_outbus, rsp_ready,
    input  req_ready, alu_start, alu_s, alu_inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, alu_finish, alu_outbus, rsp_ready,
    output req_ready, alu_start, alu_s, alu_inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
  );
endinterface

// File: rtl/alu16_op_issuer.sv
// ALU16 operation issuer: accepts one request, sequences the ALU start/opcode
// handshake and operand bus, collects one or two result words, and returns
// them through a valid/ready response. A watchdog turns a hung ALU into an
// error response. Everything driven toward the ALU and the host is registered
// except req_ready and busy, which decode the state register directly.
module alu16_op_issuer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic             clk,
  input  logic             rst,
  alu16_op_issuer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_Y   = 3'd1,
    WAIT_FIN = 3'd2,
    CAPT_LO  = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Watchdog holds the number of cycles elapsed since the start pulse while
  // waiting; a finish in the very cycle the limit is reached still wins.
  localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] wd_q, wd_d;

  logic          latch_en;
  logic [1:0]    op_q;
  logic [W-1:0]  y_q;

  logic          start_q, start_d;
  logic [3:0]    s_q, s_d;
  logic [W-1:0]  inbus_q, inbus_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          err_q, err_d;

  // Next-state and next-registered-output decode
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    latch_en = 1'b0;
    start_d  = 1'b0;
    s_d      = s_q;
    inbus_d  = '0;
    vld_d    = vld_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (bus.req_valid) begin
          latch_en = 1'b1;
          start_d  = 1'b1;
          s_d      = {2'b00, bus.req_op};
          inbus_d  = bus.req_x;
          err_d    = 1'b0;
          state_d  = LOAD_Y;
        end
      end

      LOAD_Y: begin
        inbus_d = y_q;
        wd_d    = wd_q + TW'(1);
        state_d = WAIT_FIN;
      end

      WAIT_FIN: begin
        wd_d = wd_q + TW'(1);
        if (bus.alu_finish) begin
          hi_d  = bus.alu_outbus;
          err_d = 1'b0;
          if (!op_q[1]) begin
            // add/sub: single result word, low half reads as zero
            lo_d    = '0;
            vld_d   = 1'b1;
            s_d     = 4'b0000;
            state_d = RESP;
          end else begin
            // mul/div: low product word / quotient follows next cycle
            state_d = CAPT_LO;
          end
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          vld_d   = 1'b1;
          s_d     = 4'b0000;
          state_d = RESP;
        end
      end

      CAPT_LO: begin
        lo_d    = bus.alu_outbus;
        vld_d   = 1'b1;
        s_d     = 4'b0000;
        state_d = RESP;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= '0;
      start_q <= 1'b0;
      s_q     <= 4'b0000;
      inbus_q <= '0;
      vld_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      start_q <= start_d;
      s_q     <= s_d;
      inbus_q <= inbus_d;
      vld_q   <= vld_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Operand capture at request accept; only read after a fresh accept
  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_q <= bus.req_op;
      y_q  <= bus.req_y;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.alu_start = start_q;
  assign bus.alu_s     = s_q;
  assign bus.alu_inbus = inbus_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_lo    = lo_q;
  assign bus.rsp_err   = err_q;

  // The start strobe never lasts more than one cycle
  a_start_pulse: assert property (@(posedge clk) disable iff (rst)
    start_q |=> !start_q);

  // A stalled response keeps its payload
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (vld_q && !bus.rsp_ready) |=> (vld_q && $stable(hi_q) && $stable(lo_q) && $stable(err_q)));

endmodule

// File: tb/tb_alu16_op_issuer.sv
// Bench for alu16_op_issuer: directed operations against a small ALU model,
// with a timestamp-based reference model checked every cycle.
module tb_alu16_op_issuer;
  localparam int W       = 16;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;

  logic clk = 1'b0;
  logic rst;

  alu16_op_issuer_if #(.W(W)) bus ();

  alu16_op_issuer #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALU model: finish F cycles after the start pulse with a high word,
  // then present the low word in the following cycle.
  int           alu_f;
  logic [W-1:0] alu_hi, alu_lo;
  logic         alu_fin_m, host_fin;
  logic [W-1:0] alu_out_m;

  assign bus.alu_finish = alu_fin_m | host_fin;
  assign bus.alu_outbus = alu_out_m;

  initial begin
    alu_fin_m = 1'b0;
    alu_out_m = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.alu_start && alu_f >= 0) begin
        repeat (alu_f) begin @(posedge clk); #1; end
        alu_fin_m = 1'b1;
        alu_out_m = alu_hi;
        @(posedge clk); #1;
        alu_fin_m = 1'b0;
        alu_out_m = alu_lo;
        @(posedge clk); #1;
        alu_out_m = '0;
      end
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model in terms of event times: accept cycle, finish cycle,
  // response cycle. Cycle k after accept: k=1 start pulse with x, k=2 y.
  int           cyc = 0;
  int           t_acc, t_rsp, t_fin;
  bit           m_act, m_rsp, m_fin, m_err;
  logic [1:0]   m_op;
  logic [W-1:0] m_x, m_y, m_hi, m_lo;

  task automatic compare_loop();
    int           k;
    bit           rv, eb;
    logic [3:0]   es;
    logic [W-1:0] ei;
    m_act = 0; m_rsp = 0; m_fin = 0; m_err = 0;
    t_acc = 0; t_rsp = 0; t_fin = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_act = 0; m_rsp = 0; m_fin = 0;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_alu_start", bus.alu_start, 0);
        check("rst_alu_inbus", bus.alu_inbus, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        continue;
      end
      k  = cyc - t_acc;
      rv = m_act && m_rsp && (cyc >= t_rsp);
      eb = m_act && (k >= 1);
      es = (eb && !rv) ? {2'b00, m_op} : 4'h0;
      ei = (m_act && k == 1) ? m_x : ((m_act && k == 2) ? m_y : '0);
      check("mdl_busy", bus.busy, eb);
      check("mdl_req_ready", bus.req_ready, !eb);
      check("mdl_alu_start", bus.alu_start, m_act && k == 1);
      check("mdl_alu_s", bus.alu_s, es);
      check("mdl_alu_inbus", bus.alu_inbus, ei);
      check("mdl_rsp_valid", bus.rsp_valid, rv);
      if (rv) begin
        check("mdl_rsp_hi", bus.rsp_hi, m_hi);
        check("mdl_rsp_lo", bus.rsp_lo, m_lo);
        check("mdl_rsp_err", bus.rsp_err, m_err);
      end
      if (!m_act) begin
        if (bus.req_valid) begin
          m_act = 1; t_acc = cyc; m_rsp = 0; m_fin = 0;
          m_op = bus.req_op; m_x = bus.req_x; m_y = bus.req_y;
        end
      end else if (!m_rsp) begin
        if (m_fin) begin
          if (cyc == t_fin + 1) begin
            m_lo = bus.alu_outbus; m_err = 0; m_rsp = 1; t_rsp = cyc + 1;
          end
        end else if (k >= 2 && bus.alu_finish) begin
          m_hi = bus.alu_outbus; m_err = 0;
          if (!m_op[1]) begin
            m_lo = '0; m_rsp = 1; t_rsp = cyc + 1;
          end else begin
            m_fin = 1; t_fin = cyc;
          end
        end else if (k == TIMEOUT + 1) begin
          m_err = 1; m_hi = '0; m_lo = '0; m_rsp = 1; t_rsp = cyc + 1;
        end
      end else if (rv && bus.rsp_ready) begin
        m_act = 0;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // One full operation with hand-computed response and latency
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y, input int f,
                        input logic [W-1:0] ahi, input logic [W-1:0] alo,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic eerr,
                        input int elat, input int stall);
    int n;
    alu_f = f; alu_hi = ahi; alu_lo = alo;
    issue(op, x, y);
    check({name, "_start"}, bus.alu_start, 1);
    check({name, "_inbus_x"}, bus.alu_inbus, x);
    check({name, "_alu_s"}, bus.alu_s, {2'b00, op});
    n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_rsp_valid"}, bus.rsp_valid, 1);
    check({name, "_latency"}, n, elat);
    check({name, "_hi"}, bus.rsp_hi, ehi);
    check({name, "_lo"}, bus.rsp_lo, elo);
    check({name, "_err"}, bus.rsp_err, eerr);
    if (stall > 0) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_x     = 16'hAAAA;
      bus.req_y     = 16'h5555;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({name, "_stall_hi"}, bus.rsp_hi, ehi);
      check({name, "_stall_lo"}, bus.rsp_lo, elo);
      check({name, "_stall_req_ready"}, bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({name, "_done_busy"}, bus.busy, 0);
    check({name, "_done_req_ready"}, bus.req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_x = '0; bus.req_y = '0;
    bus.rsp_ready = 1'b0;
    host_fin = 1'b0;
    alu_f = -1; alu_hi = '0; alu_lo = '0;
    fork
      compare_loop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_alu_s", bus.alu_s, 0);
    check("reset_rsp_hi", bus.rsp_hi, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add",  2'b00, 16'h1234, 16'h0F0F, 3,  16'h2143, 16'h0000, 16'h2143, 16'h0000, 1'b0, 4, 0);
    run_op("mul",  2'b10, 16'h0003, 16'hFFFE, 5,  16'hFFFF, 16'hFFFA, 16'hFFFF, 16'hFFFA, 1'b0, 7, 0);
    run_op("div",  2'b11, 16'd100,  16'd7,    4,  16'h0002, 16'h000E, 16'h0002, 16'h000E, 1'b0, 6, 5);
    run_op("sub",  2'b01, 16'h0005, 16'h0007, 1,  16'hFFFE, 16'h0000, 16'hFFFE, 16'h0000, 1'b0, 2, 0);
    // ALU finishes one cycle after expiry: error response, late finish ignored
    run_op("tmo",  2'b00, 16'h0001, 16'h0002, TIMEOUT + 1, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 1'b1, TIMEOUT + 1, 2);
    // Finish exactly at the watchdog limit wins
    run_op("edge", 2'b10, 16'h0101, 16'h0202, TIMEOUT, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0, TIMEOUT + 2, 0);

    // Stray finish while idle
    host_fin = 1'b1;
    @(posedge clk); #1;
    host_fin = 1'b0;
    check("stray_busy", bus.busy, 0);
    check("stray_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("stray_req_ready", bus.req_ready, 1);

    // Reset while the start pulse is out
    alu_f = -1;
    issue(2'b00, 16'h4444, 16'h5555);
    check("rst_s_start_before", bus.alu_start, 1);
    rst = 1'b1;
    #1;
    check("rst_s_start_after", bus.alu_start, 0);
    check("rst_s_inbus_after", bus.alu_inbus, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during the wait for finish
    issue(2'b11, 16'h0010, 16'h0003);
    repeat (5) begin @(posedge clk); #1; end
    check("rst_w_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rst_w_busy_after", bus.busy, 0);
    check("rst_w_req_ready", bus.req_ready, 1);
    check("rst_w_alu_s", bus.alu_s, 0);
    check("rst_w_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("post", 2'b00, 16'h0001, 16'h0002, 2, 16'h0003, 16'h0000, 16'h0003, 16'h0000, 1'b0, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, run=%0d failed=%0d", n_run, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/alu16_op_issuer.md
Name: alu16_op_issuer

Overview:
- Host-side initiator for the 16-bit ALU control unit and datapath. It accepts one operation request at a time, drives the ALU `start`/`s` handshake and operand bus, waits for `finish`, then returns the result through a valid/ready response port.
- Includes a watchdog so that a hung ALU cannot stall the host.
- Sits between the processor sequencer and the ALU16 block.

Parameters:
- W, 16, operand/result word width.
- TIMEOUT, 64, maximum cycles from start pulse to `finish` before an error response is returned; must be at least 2.
- TW, 7, watchdog counter width; must satisfy TW >= clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_op  in  2  operation: 00 add, 01 sub, 10 mul (Booth), 11 div.
- req_x  in  W  first operand (multiplicand / dividend).
- req_y  in  W  second operand (multiplier / divisor).
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_s  out  4  opcode to the ALU; {2'b00, op}, held from the start cycle until the response is buffered.
- alu_inbus  out  W  operand bus to the ALU datapath.
- alu_finish  in  1  ALU completion strobe.
- alu_outbus  in  W  ALU result bus.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes the response.
- rsp_hi  out  W  add/sub: the result; mul: high product word; div: remainder.
- rsp_lo  out  W  add/sub: 0; mul: low product word; div: quotient.
- rsp_err  out  1  set when the watchdog expired.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, watchdog = 0. All outputs are 0 except `req_ready` = 1.
- IDLE:
  - `req_ready` = 1.
  - When `req_valid` is high: latch op/x/y, drive `alu_start` = 1, `alu_inbus` = x, `alu_s` = op, then go to LOAD_Y.
- LOAD_Y (1 cycle): `alu_inbus` = y, `alu_start` = 0; go to WAIT.
- WAIT:
  - `alu_inbus` = 0. The watchdog increments every cycle and is cleared on entry to IDLE.
  - `alu_finish` high, op is add/sub: capture `alu_outbus` into `rsp_hi`, set `rsp_lo` = 0, go to RESP.
  - `alu_finish` high, op is mul/div: capture `alu_outbus` into `rsp_hi` (high word / remainder), go to CAPT_LO.
  - Watchdog reaches TIMEOUT with no finish: set `rsp_err` = 1, `rsp_hi` = `rsp_lo` = 0, go to RESP.
  - If `alu_finish` and expiry occur in the same cycle, finish wins and `rsp_err` = 0.
- CAPT_LO (1 cycle): capture `alu_outbus` into `rsp_lo` (low product word / quotient); go to RESP. A `finish` arriving in this cycle is ignored.
- RESP:
  - `rsp_valid` = 1; `rsp_hi`, `rsp_lo` and `rsp_err` are held stable while `rsp_valid` is high and `rsp_ready` is low.
  - On `rsp_valid` & `rsp_ready`, go to IDLE. The next request can be accepted in the following cycle.
  - `req_ready` = 0 in RESP; there is no overlap of request and response.
- `alu_finish` outside WAIT/CAPT_LO is ignored; no state change.
- `req_valid` outside IDLE is ignored; the request is not latched because `req_ready` = 0.
- Latency, request accept to `rsp_valid`:
  - add/sub: F+1 cycles.
  - mul/div: F+2 cycles.
  - F = cycles from the start pulse to `alu_finish`.
- `rst` asserted in any state aborts the operation immediately; no response is produced and `alu_start` deasserts asynchronously.
- All outputs are registered except `req_ready` and `busy`, which are decoded from the state register only.

Test Plan:
- Add: x=0x1234, y=0x0F0F, op=00, ALU model asserts finish with 0x2143 → `alu_start` for exactly 1 cycle with `alu_inbus`=0x1234, next cycle 0x0F0F; response hi=0x2143, lo=0, err=0.
- Mul: x=0x0003, y=0xFFFE, op=10, finish with outbus 0xFFFF then 0xFFFA → hi=0xFFFF, lo=0xFFFA, `alu_s`=4'b0010 held until RESP.
- Div with stalled host: x=100, y=7, finish with 0x0002 then 0x000E; hold `rsp_ready`=0 for 5 cycles → hi=2, lo=14 stable, `req_ready`=0 throughout; accepted on the first cycle `rsp_ready`=1.
- Timeout: TIMEOUT=64, ALU never finishes → `rsp_valid` with err=1, hi=lo=0; a finish one cycle later is ignored; a new request is accepted afterwards.
- Finish in the same cycle as expiry → err=0 and data captured. A stray finish in IDLE → no response, state unchanged.
- `rst` pulsed during WAIT → outputs return to reset values with `req_ready`=1; the next request completes normally.
